// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ID/EX register layout, forwarding selects and ALU bubble opcode.
package pipe_pkg;
   localparam int DW = 32;
   localparam int OW = 4;
   localparam int RW = 5;
   localparam logic [OW-1:0] ALU_OP_AND = 4'b0000;
   typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;
   typedef struct packed {
      logic          valid;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
      logic          alu_src;
      logic [OW-1:0] alu_op;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic [RW-1:0] rd;
      logic [DW-1:0] pc;
      logic [DW-1:0] rs1_data;
      logic [DW-1:0] rs2_data;
      logic [DW-1:0] imm;
   } id_ex_t;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the youngest in-flight producer (MEM over WB) for one operand; x0 never forwards.
module forward_unit
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] rs,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
   input  logic                      mem_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
   input  logic                      wb_reg_write,
   output fwd_sel_e                  sel
);
   always_comb
      sel = (mem_reg_write && mem_rd != '0 && mem_rd == rs) ? FWD_MEM :
            (wb_reg_write && wb_rd != '0 && wb_rd == rs)    ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register, ALU operand muxing and hazard stall.
// EX_FORWARDING_EN enables MEM/WB forwarding with load-use-only stalls; otherwise all RAW hazards stall.
module ex_operand_stage
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int OPCODE_LENGTH  = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic [DATA_WIDTH-1:0]     id_pc,
   input  logic [DATA_WIDTH-1:0]     id_rs1_data,
   input  logic [DATA_WIDTH-1:0]     id_rs2_data,
   input  logic [DATA_WIDTH-1:0]     id_imm,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
   input  logic                      id_alu_src,
   input  logic                      id_reg_write,
   input  logic                      id_mem_read,
   input  logic                      id_mem_write,
   input  logic                      flush,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
   input  logic                      mem_reg_write,
   input  logic [DATA_WIDTH-1:0]     mem_result,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
   input  logic                      wb_reg_write,
   input  logic [DATA_WIDTH-1:0]     wb_result,
   output logic [DATA_WIDTH-1:0]     SrcA,
   output logic [DATA_WIDTH-1:0]     SrcB,
   output logic [OPCODE_LENGTH-1:0]  Operation,
   output logic [DATA_WIDTH-1:0]     ex_store_data,
   output logic [DATA_WIDTH-1:0]     ex_pc,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic                      ex_valid,
   output logic                      ex_reg_write,
   output logic                      ex_mem_read,
   output logic                      ex_mem_write,
   output logic                      stall
);
   id_ex_t id_ex_d, id_ex_q;
   logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;
   // Bubbles are all-zero, which also gives Operation = ALU_OP_AND.
   always_comb begin
      id_ex_d = '0;
      id_ex_d.alu_op = ALU_OP_AND;
      if (!flush && !stall)
         id_ex_d = '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read,
                     mem_write: id_mem_write, alu_src: id_alu_src, alu_op: id_alu_op,
                     rs1: id_rs1, rs2: id_rs2, rd: id_rd, pc: id_pc,
                     rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) id_ex_q <= '0;
      else       id_ex_q <= id_ex_d;
`ifdef EX_FORWARDING_EN
   fwd_sel_e sel_a, sel_b;
   forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
      .rs(id_ex_q.rs1), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_a));
   forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
      .rs(id_ex_q.rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_b));
   assign rs1_fwd = sel_a == FWD_MEM ? mem_result : sel_a == FWD_WB ? wb_result : id_ex_q.rs1_data;
   assign rs2_fwd = sel_b == FWD_MEM ? mem_result : sel_b == FWD_WB ? wb_result : id_ex_q.rs2_data;
   // Only a load in EX is too late to forward; the write-through regfile covers WB.
   assign stall = id_ex_q.valid && id_ex_q.mem_read && id_ex_q.rd != '0 &&
                  (id_ex_q.rd == id_rs1 || id_ex_q.rd == id_rs2);
`else
   logic unused_nofwd;
   assign rs1_fwd = id_ex_q.rs1_data;
   assign rs2_fwd = id_ex_q.rs2_data;
   assign stall = (id_ex_q.valid && id_ex_q.reg_write && id_ex_q.rd != '0 &&
                   (id_ex_q.rd == id_rs1 || id_ex_q.rd == id_rs2)) ||
                  (mem_reg_write && mem_rd != '0 && (mem_rd == id_rs1 || mem_rd == id_rs2));
   assign unused_nofwd = ^{mem_result, wb_result, wb_rd, wb_reg_write, id_ex_q.rs1, id_ex_q.rs2};
`endif
   assign SrcA          = rs1_fwd;
   assign SrcB          = id_ex_q.alu_src ? id_ex_q.imm : rs2_fwd;
   assign ex_store_data = rs2_fwd;
   assign Operation     = id_ex_q.alu_op;
   assign ex_pc         = id_ex_q.pc;
   assign ex_rd         = id_ex_q.rd;
   assign ex_valid      = id_ex_q.valid;
   assign ex_reg_write  = id_ex_q.reg_write;
   assign ex_mem_read   = id_ex_q.mem_read;
   assign ex_mem_write  = id_ex_q.mem_write;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed table, hazard sequences and random run against a reference model.
module tb_ex_operand_stage;
`ifdef EX_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic clk, reset;
   logic id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
   logic [3:0] id_alu_op;
   logic mem_reg_write, wb_reg_write;
   logic [31:0] mem_result, wb_result;
   logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
   logic [3:0] Operation;
   logic [4:0] ex_rd;
   logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
   int passed = 0, total = 0;

   ex_operand_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .flush(flush), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .mem_result(mem_result), .wb_rd(wb_rd),
      .wb_reg_write(wb_reg_write), .wb_result(wb_result), .SrcA(SrcA), .SrcB(SrcB),
      .Operation(Operation), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .stall(stall));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic v, rw, mr, mw, src;
      logic [3:0] op;
      logic [4:0] rs1, rs2, rd;
      logic [31:0] pc, d1, d2, imm;
   } ex_t;

   typedef struct {
      logic [4:0] rs1; logic [31:0] d1; logic [4:0] rs2; logic [31:0] d2;
      logic [31:0] imm; logic src; logic [3:0] op;
      logic [4:0] mrd; logic mrw; logic [31:0] mres;
      logic [4:0] wrd; logic wrw; logic [31:0] wres;
      logic [31:0] a_f, a_n, b_f, b_n, sd_f, sd_n;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_alu_src = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
      mem_rd = 0; mem_reg_write = 0; mem_result = 0;
      wb_rd = 0; wb_reg_write = 0; wb_result = 0;
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
      if (FWD && mem_reg_write && mem_rd != 0 && mem_rd == idx) return mem_result;
      if (FWD && wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_result;
      return d;
   endfunction

   function automatic logic hit(input logic [4:0] r);
      return r != 0 && (r == id_rs1 || r == id_rs2);
   endfunction

   function automatic logic exp_stall(input ex_t m);
      if (FWD) return m.v && m.mr && hit(m.rd);
      return (m.v && m.rw && hit(m.rd)) || (mem_reg_write && hit(mem_rd));
   endfunction

   vec_t vecs[6];
   ex_t m, nm;

   initial begin
      vecs[0] = '{1, 10, 2, 0, 7, 1, 4'hD, 0, 0, 0, 0, 0, 0, 10, 10, 7, 7, 0, 0};
      vecs[1] = '{3, 'h33, 2, 'h44, 0, 0, 4'h2, 3, 1, 'h11, 3, 1, 'h22, 'h11, 'h33, 'h44, 'h44, 'h44, 'h44};
      vecs[2] = '{3, 'h33, 2, 'h44, 0, 0, 4'h2, 3, 0, 'h11, 3, 1, 'h22, 'h22, 'h33, 'h44, 'h44, 'h44, 'h44};
      vecs[3] = '{0, 0, 0, 0, 0, 0, 4'h1, 0, 1, 'hFF, 0, 1, 'hEE, 0, 0, 0, 0, 0, 0};
      vecs[4] = '{1, 5, 6, 5, 0, 0, 4'h3, 0, 0, 0, 6, 1, 'h66, 5, 5, 'h66, 5, 'h66, 5};
      vecs[5] = '{1, 5, 6, 5, 'h123, 1, 4'h4, 6, 1, 'h77, 0, 0, 0, 5, 5, 'h123, 'h123, 'h77, 5};
      idle();
      reset = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_valid", ex_valid, 0);
      chk("reset_op", Operation, 0);
      chk("reset_srca", SrcA, 0);
      chk("reset_srcb", SrcB, 0);
      chk("reset_stall", stall, 0);
      @(negedge clk) reset = 0;
      foreach (vecs[i]) begin
         @(negedge clk);
         idle();
         id_valid = 1; id_rs1 = vecs[i].rs1; id_rs1_data = vecs[i].d1;
         id_rs2 = vecs[i].rs2; id_rs2_data = vecs[i].d2; id_imm = vecs[i].imm;
         id_alu_src = vecs[i].src; id_alu_op = vecs[i].op; id_pc = 32'h100 + 4 * i;
         @(negedge clk);
         idle();
         mem_rd = vecs[i].mrd; mem_reg_write = vecs[i].mrw; mem_result = vecs[i].mres;
         wb_rd = vecs[i].wrd; wb_reg_write = vecs[i].wrw; wb_result = vecs[i].wres;
         #1;
         chk($sformatf("vec%0d_srca", i), SrcA, FWD ? vecs[i].a_f : vecs[i].a_n);
         chk($sformatf("vec%0d_srcb", i), SrcB, FWD ? vecs[i].b_f : vecs[i].b_n);
         chk($sformatf("vec%0d_store", i), ex_store_data, FWD ? vecs[i].sd_f : vecs[i].sd_n);
         chk($sformatf("vec%0d_op", i), Operation, vecs[i].op);
         chk($sformatf("vec%0d_valid", i), ex_valid, 1);
         chk($sformatf("vec%0d_pc", i), ex_pc, 32'h100 + 4 * i);
      end
      // load-use: lw x4 then a consumer of x4
      @(negedge clk);
      idle(); id_valid = 1; id_rd = 4; id_mem_read = 1; id_reg_write = 1;
      @(negedge clk);
      idle(); id_valid = 1; id_rs1 = 4; id_rd = 5; id_reg_write = 1;
      #1;
      chk("lu_stall", stall, 1);
      chk("lu_ex_mem_read", ex_mem_read, 1);
      @(negedge clk);
      mem_rd = 4; mem_reg_write = 1; mem_result = 32'h99;
      #1;
      chk("lu_bubble", ex_valid, 0);
      chk("lu_stall_after", stall, FWD ? 0 : 1);
      @(negedge clk);
      #1;
      chk("lu_valid", ex_valid, FWD ? 1 : 0);
      chk("lu_fwd_srca", SrcA, FWD ? 32'h99 : 0);
      // back-to-back dependent ALU op
      @(negedge clk);
      idle(); id_valid = 1; id_rd = 7; id_reg_write = 1;
      @(negedge clk);
      idle(); id_valid = 1; id_rs2 = 7;
      #1;
      chk("dep_stall", stall, FWD ? 0 : 1);
      // flush
      @(negedge clk);
      idle(); id_valid = 1; id_reg_write = 1; id_rd = 9; id_alu_op = 5; flush = 1;
      @(negedge clk);
      idle();
      #1;
      chk("flush_valid", ex_valid, 0);
      chk("flush_rw", ex_reg_write, 0);
      chk("flush_op", Operation, 0);
      // asynchronous reset mid-operation
      @(negedge clk);
      idle(); id_valid = 1; id_rd = 8; id_reg_write = 1; id_alu_op = 6;
      @(negedge clk);
      idle();
      #1;
      chk("pre_areset_valid", ex_valid, 1);
      reset = 1;
      #1;
      chk("areset_valid", ex_valid, 0);
      chk("areset_op", Operation, 0);
      // random run against the model
      nm = '0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         reset = 0;
         m = nm;
         id_valid = ($urandom % 4) != 0; id_pc = $urandom;
         id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
         id_rs1 = 5'($urandom % 4); id_rs2 = 5'($urandom % 4); id_rd = 5'($urandom % 4);
         id_alu_op = 4'($urandom); id_alu_src = 1'($urandom);
         id_reg_write = 1'($urandom); id_mem_read = ($urandom % 3) == 0; id_mem_write = 1'($urandom);
         flush = ($urandom % 10) == 0;
         mem_rd = 5'($urandom % 4); mem_reg_write = 1'($urandom); mem_result = $urandom;
         wb_rd = 5'($urandom % 4); wb_reg_write = 1'($urandom); wb_result = $urandom;
         #1;
         chk("rnd_srca", SrcA, fwd(m.rs1, m.d1));
         chk("rnd_srcb", SrcB, m.src ? m.imm : fwd(m.rs2, m.d2));
         chk("rnd_store", ex_store_data, fwd(m.rs2, m.d2));
         chk("rnd_op", Operation, m.op);
         chk("rnd_ctrl", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, {m.v, m.rw, m.mr, m.mw});
         chk("rnd_pc", ex_pc, m.pc);
         chk("rnd_rd", ex_rd, m.rd);
         chk("rnd_stall", stall, exp_stall(m));
         if (flush || exp_stall(m)) nm = '0;
         else nm = '{v: id_valid, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
                     src: id_alu_src, op: id_alu_op, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                     pc: id_pc, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm};
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
